ps2_frame_rx: RTL

PS/2 device-to-host receiver front end. It synchronises and deglitches raw kclk/kdata and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). It merges prefix bytes (E0/E1/F0) into one multi-byte scan code. Its keycodeout and newkeypress outputs feed the keyboard MMIO/IRQ wrapper, which latches keycodeout on the rising edge of newkeypress.

---
 rtl/ps2_frame_rx_pkg.sv | 21 ++
 rtl/ps2_frame_rx_if.sv | 21 ++
 rtl/ps2_in_filter.sv | 52 +++++
 rtl/ps2_frame_rx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ps2_frame_rx_pkg.sv
// Shared constants for the PS/2 receiver: scan-code prefix bytes and the
// frame FSM state encoding.
`timescale 1ns/1ps
package ps2_frame_rx_pkg;

  localparam logic [7:0] PS2_PREFIX_E0 = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_E1 = 8'hE1;
  localparam logic [7:0] PS2_PREFIX_F0 = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PREFIX_E0) || (b == PS2_PREFIX_E1) || (b == PS2_PREFIX_F0);
  endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// Receiver-side result bus: assembled scan code plus per-byte status pulses.
// The receiver drives it through master; the MMIO/IRQ wrapper reads through slave.
`timescale 1ns/1ps
interface ps2_frame_rx_if;

  logic [31:0] keycodeout;
  logic        newkeypress;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;

  modport master (
    output keycodeout, newkeypress, rx_byte, rx_valid, parity_err, frame_err
  );

  modport slave (
    input keycodeout, newkeypress, rx_byte, rx_valid, parity_err, frame_err
  );

endinterface

// File: rtl/ps2_in_filter.sv
// Pad-side conditioning: synchronises kclk/kdata, deglitches kclk and emits a
// single-cycle pulse on each falling edge of the filtered clock.
`timescale 1ns/1ps
module ps2_in_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kclk,
  input  logic kdata,
  output logic kdata_s,
  output logic kclk_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] kclk_sync;
  logic [SYNC_STAGES-1:0] kdata_sync;
  logic [CW-1:0]          cnt;
  logic                   kclk_filt;
  logic                   kclk_s;

  assign kclk_s  = kclk_sync[SYNC_STAGES-1];
  assign kdata_s = kdata_sync[SYNC_STAGES-1];

  // The filtered clock only moves after FILTER_LEN consecutive samples disagree
  // with it; the fall pulse lines up with the cycle the filtered value drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_sync  <= '1;
      kdata_sync <= '1;
      cnt        <= '0;
      kclk_filt  <= 1'b1;
      kclk_fall  <= 1'b0;
    end else begin
      kclk_sync  <= {kclk_sync[SYNC_STAGES-2:0], kclk};
      kdata_sync <= {kdata_sync[SYNC_STAGES-2:0], kdata};
      kclk_fall  <= 1'b0;
      if (kclk_s == kclk_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        kclk_filt <= kclk_s;
        kclk_fall <= kclk_filt;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: deserialises 11-bit frames, checks
// parity/stop/timeout and merges E0/E1/F0 prefixes into one scan code.
`timescale 1ns/1ps
module ps2_frame_rx
  import ps2_frame_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 6250
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           kclk,
  input  logic           kdata,
  ps2_frame_rx_if.master rx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic kdata_s;
  logic kclk_fall;

  ps2_in_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_in_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .kclk      (kclk),
    .kdata     (kdata),
    .kdata_s   (kdata_s),
    .kclk_fall (kclk_fall)
  );

  ps2_state_e  state, state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;
  logic        par_bit, par_bit_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic [23:0] acc, acc_n;
  logic [31:0] keycode, keycode_n;
  logic [7:0]  rx_byte_r, rx_byte_n;
  logic        valid_r, valid_n;
  logic        newkey_r, newkey_n;
  logic        perr_r, perr_n;
  logic        ferr_r, ferr_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      acc       <= '0;
      keycode   <= '0;
      rx_byte_r <= '0;
      valid_r   <= 1'b0;
      newkey_r  <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      par_bit   <= par_bit_n;
      tmo_cnt   <= tmo_cnt_n;
      acc       <= acc_n;
      keycode   <= keycode_n;
      rx_byte_r <= rx_byte_n;
      valid_r   <= valid_n;
      newkey_r  <= newkey_n;
      perr_r    <= perr_n;
      ferr_r    <= ferr_n;
    end
  end

  // A fall always takes priority over an expiring timeout in the same cycle.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_bit_n = par_bit;
    tmo_cnt_n = tmo_cnt + TW'(1);
    acc_n     = acc;
    keycode_n = keycode;
    rx_byte_n = rx_byte_r;
    valid_n   = 1'b0;
    newkey_n  = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;

    if (state == IDLE || kclk_fall) begin
      tmo_cnt_n = '0;
    end

    if (kclk_fall) begin
      unique case (state)
        IDLE: begin
          if (!kdata_s) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shift_n   = {kdata_s, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = PARITY;
          end
        end
        PARITY: begin
          par_bit_n = kdata_s;
          state_n   = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!kdata_s) begin
            ferr_n = 1'b1;
            acc_n  = '0;
          end else if (^{shift, par_bit}) begin
            valid_n   = 1'b1;
            rx_byte_n = shift;
            if (is_prefix(shift)) begin
              acc_n = {acc[15:0], shift};
            end else begin
              keycode_n = {acc, shift};
              newkey_n  = 1'b1;
              acc_n     = '0;
            end
          end else begin
            perr_n = 1'b1;
            acc_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
      ferr_n    = 1'b1;
      state_n   = IDLE;
      acc_n     = '0;
      tmo_cnt_n = '0;
    end
  end

  assign rx.keycodeout  = keycode;
  assign rx.newkeypress = newkey_r;
  assign rx.rx_byte     = rx_byte_r;
  assign rx.rx_valid    = valid_r;
  assign rx.parity_err  = perr_r;
  assign rx.frame_err   = ferr_r;

endmodule
